// File: rtl/uart_receiver_fifo.sv
// rtl/uart_receiver_fifo.sv - oversampling UART receiver with majority-vote sampling and FWFT FIFO
module uart_receiver_fifo #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int OVERSAMPLE      = 16,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          dout,
  output logic                          empty,
  input  logic                          re,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);
  localparam int DIV_RAW = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [SW-1:0] SC_V0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_V1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SC_VOTE = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);

  logic                 rx_meta, rxs, rxs_d;
  logic [DW-1:0]        div_cnt;
  logic                 tick, start_det;
  logic [2:0]           state;
  logic [SW-1:0]        sc;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg, res_data;
  logic                 fe, pe, s0, s1, vote, par_exp;
  logic                 res_valid, res_fe, res_pe;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 full, good, do_wr, do_rd;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign start_det = (state == S_IDLE) && rxs_d && !rxs;
  assign tick      = (div_cnt == DW'(DIV - 1));

  // Restarting the divider on the start edge keeps the sample points centred in each bit.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                div_cnt <= '0;
    else if (start_det || tick) div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end

  assign vote    = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign par_exp = (^shreg) ^ (PARITY == 2);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= S_IDLE;
      sc        <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      fe        <= 1'b0;
      pe        <= 1'b0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      res_valid <= 1'b0;
      res_fe    <= 1'b0;
      res_pe    <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= 1'b0;
      if (start_det) begin
        state <= S_START;
        sc    <= '0;
        fe    <= 1'b0;
        pe    <= 1'b0;
      end else if (state != S_IDLE && tick) begin
        sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
        if (sc == SC_V0) s0 <= rxs;
        if (sc == SC_V1) s1 <= rxs;
        case (state)
          S_START: begin
            if (sc == SC_VOTE && vote) begin
              state <= S_IDLE;
            end else if (sc == SC_LAST) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end
          S_DATA: begin
            if (sc == SC_VOTE) shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (sc == SC_LAST) begin
              if (bit_idx == 4'(DATA_BITS - 1)) begin
                bit_idx <= '0;
                state   <= (PARITY != 0) ? S_PARITY : S_STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
          S_PARITY: begin
            if (sc == SC_VOTE && vote != par_exp) pe <= 1'b1;
            if (sc == SC_LAST) state <= S_STOP;
          end
          S_STOP: begin
            // Resolve at the last vote point so a back-to-back start edge is not missed.
            if (sc == SC_VOTE) begin
              if (!vote) fe <= 1'b1;
              if (bit_idx == 4'(STOP_BITS - 1)) begin
                state     <= S_IDLE;
                res_valid <= 1'b1;
                res_fe    <= fe | ~vote;
                res_pe    <= pe;
                res_data  <= shreg;
              end
            end
            if (sc == SC_LAST) bit_idx <= bit_idx + 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign good  = res_valid && !res_fe && !res_pe;
  assign do_wr = good && !full;
  assign do_rd = re && !empty;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      frame_err  <= res_valid && res_fe;
      parity_err <= res_valid && !res_fe && res_pe;
      overrun    <= good && full;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_wr) mem[wr_ptr] <= res_data;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_receiver_fifo.sv
// tb/tb_uart_receiver_fifo.sv - randomized bench with frame-level reference model for uart_receiver_fifo
`timescale 1ns/1ps
module tb_uart_receiver_fifo;
  localparam int OS = 16;
  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rxd [NI];
  logic       re  [NI];
  logic [7:0] dout0;
  logic [6:0] dout1;
  logic [2:0] count0;
  logic [4:0] count1;
  logic       empty_w [NI];
  logic       fe_w [NI];
  logic       pe_w [NI];
  logic       ov_w [NI];

  uart_receiver_fifo #(.CLOCK_FREQUENCY(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(OS),
                       .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk_in(clk), .rst_in(rst_n), .rxd(rxd[0]), .dout(dout0), .empty(empty_w[0]), .re(re[0]),
    .count(count0), .frame_err(fe_w[0]), .parity_err(pe_w[0]), .overrun(ov_w[0]));

  uart_receiver_fifo #(.CLOCK_FREQUENCY(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(OS),
                       .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) u1 (
    .clk_in(clk), .rst_in(rst_n), .rxd(rxd[1]), .dout(dout1), .empty(empty_w[1]), .re(re[1]),
    .count(count1), .frame_err(fe_w[1]), .parity_err(pe_w[1]), .overrun(ov_w[1]));

  function automatic int dbits(int i);  return (i == 0) ? 8 : 7;  endfunction
  function automatic int par(int i);    return (i == 0) ? 0 : 1;  endfunction
  function automatic int nstop(int i);  return (i == 0) ? 1 : 2;  endfunction
  function automatic int depth(int i);  return (i == 0) ? 4 : 16; endfunction
  function automatic logic [31:0] dv(int i);
    return (i == 0) ? {24'b0, dout0} : {25'b0, dout1};
  endfunction
  function automatic logic [31:0] cv(int i);
    return (i == 0) ? {29'b0, count0} : {27'b0, count1};
  endfunction

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: a word queue per instance plus the single frame outcome awaiting resolution.
  logic [8:0] mem [NI][16];
  int         m_head [NI];
  int         m_n [NI];
  bit         pend_v [NI];
  int         pend_due [NI];
  int         pend_kind [NI];
  logic [8:0] pend_data [NI];
  bit         exp_fe [NI];
  bit         exp_pe [NI];
  bit         exp_ov [NI];
  int         obs_fe [NI];
  int         obs_pe [NI];
  int         obs_ov [NI];

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_head[i] = 0; m_n[i] = 0; pend_v[i] = 0;
      obs_fe[i] = 0; obs_pe[i] = 0; obs_ov[i] = 0;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < NI; i++) begin
      exp_fe[i] = 0; exp_pe[i] = 0; exp_ov[i] = 0;
      if (!rst_n) begin
        m_n[i] = 0; m_head[i] = 0; pend_v[i] = 0;
      end else begin : upd
        int pre;
        pre = m_n[i];
        if (pend_v[i] && pend_due[i] == cyc) begin
          pend_v[i] = 0;
          if (pend_kind[i] == 1)      exp_fe[i] = 1;
          else if (pend_kind[i] == 2) exp_pe[i] = 1;
          else if (pre == depth(i))   exp_ov[i] = 1;
          else begin
            mem[i][(m_head[i] + pre) % 16] = pend_data[i];
            m_n[i] = m_n[i] + 1;
          end
        end
        if (re[i] && pre > 0) begin
          m_head[i] = (m_head[i] + 1) % 16;
          m_n[i] = m_n[i] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        chk("empty", i, {31'b0, empty_w[i]}, {31'b0, m_n[i] == 0});
        chk("count", i, cv(i), m_n[i]);
        if (m_n[i] > 0) chk("dout", i, dv(i), {23'b0, mem[i][m_head[i]]});
        chk("frame_err", i, {31'b0, fe_w[i]}, {31'b0, exp_fe[i]});
        chk("parity_err", i, {31'b0, pe_w[i]}, {31'b0, exp_pe[i]});
        chk("overrun", i, {31'b0, ov_w[i]}, {31'b0, exp_ov[i]});
        if (fe_w[i]) obs_fe[i]++;
        if (pe_w[i]) obs_pe[i]++;
        if (ov_w[i]) obs_ov[i]++;
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop(int i);
    re[i] = 1'b1;
    @(negedge clk);
    re[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rxd[i] = 1'b1;
      re[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_empty", i, {31'b0, empty_w[i]}, 32'd1);
      chk("rst_count", i, cv(i), 32'd0);
      chk("rst_dout", i, dv(i), 32'd0);
      chk("rst_pulses", i, {29'b0, fe_w[i], pe_w[i], ov_w[i]}, 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Frame outcome comes from the bits on the wire; it takes effect one clock after the
  // vote point of the last stop bit (2 sync flops + edge detect + mid-bit vote).
  task automatic send_frame(int i, logic [8:0] d, bit flip, bit bad_stop, int gap);
    logic bits [16];
    logic pexp;
    int   nb;
    bits[0] = 1'b0;
    nb = 1;
    pexp = 1'b0;
    for (int b = 0; b < dbits(i); b++) begin
      bits[nb] = d[b];
      pexp = pexp ^ d[b];
      nb++;
    end
    if (par(i) != 0) begin
      if (par(i) == 2) pexp = ~pexp;
      bits[nb] = pexp ^ flip;
      nb++;
    end
    for (int s = 0; s < nstop(i); s++) begin
      bits[nb] = !(bad_stop && s == 0);
      nb++;
    end
    pend_due[i]  = (cyc + 1) + OS * (nb - 1) + OS / 2 + 5;
    pend_kind[i] = bad_stop ? 1 : ((flip && par(i) != 0) ? 2 : 0);
    pend_data[i] = d;
    pend_v[i]    = 1;
    for (int b = 0; b < nb; b++) begin
      rxd[i] = bits[b];
      repeat (OS) @(negedge clk);
    end
    rxd[i] = 1'b1;
    repeat (gap + (bad_stop ? OS : 0)) @(negedge clk);
  endtask

  task automatic random_phase(int i, int nframes);
    bit done;
    done = 0;
    fork
      begin
        for (int f = 0; f < nframes; f++) begin
          send_frame(i, 9'($urandom_range(0, (1 << dbits(i)) - 1)),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                     $urandom_range(0, 20));
        end
        done = 1;
      end
      begin
        while (!done) begin
          re[i] = ($urandom_range(0, 99) < 30);
          @(negedge clk);
        end
        re[i] = 1'b0;
      end
    join
    while (m_n[i] > 0) pop(i);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int fe0, ov0, pe1, guard;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rxd[i] = 1'b1;
      re[i] = 1'b0;
    end
    @(negedge clk);
    do_reset();
    idle(1000);

    rxd[0] = 1'b0;
    idle(5);
    rxd[0] = 1'b1;
    idle(60);
    chk("glitch_count", 0, cv(0), 32'd0);

    send_frame(0, 9'h0A5, 0, 0, 0);
    send_frame(0, 9'h03C, 0, 0, 30);
    chk("b2b_count", 0, cv(0), 32'd2);
    chk("b2b_head", 0, dv(0), 32'hA5);
    pop(0);
    chk("b2b_second", 0, dv(0), 32'h3C);
    pop(0);
    chk("b2b_empty", 0, {31'b0, empty_w[0]}, 32'd1);

    pe1 = obs_pe[1];
    send_frame(1, 9'h041, 0, 0, 30);
    chk("par_ok_count", 1, cv(1), 32'd1);
    chk("par_ok_word", 1, dv(1), 32'h41);
    send_frame(1, 9'h041, 1, 0, 30);
    chk("par_bad_count", 1, cv(1), 32'd1);
    chk("par_bad_pulses", 1, obs_pe[1] - pe1, 32'd1);
    pop(1);

    fe0 = obs_fe[0];
    send_frame(0, 9'h055, 0, 1, 10);
    send_frame(0, 9'h012, 0, 0, 30);
    chk("fe_pulses", 0, obs_fe[0] - fe0, 32'd1);
    chk("fe_next_count", 0, cv(0), 32'd1);
    chk("fe_next_word", 0, dv(0), 32'h12);

    guard = 0;
    fork
      send_frame(0, 9'h077, 0, 0, 30);
      begin
        @(negedge clk);
        while (cyc != pend_due[0] - 1 && guard < 400) begin
          guard++;
          @(negedge clk);
        end
        chk("re_align_timeout", 0, (guard < 400), 32'd1);
        re[0] = 1'b1;
        @(negedge clk);
        re[0] = 1'b0;
      end
    join
    chk("wr_rd_count", 0, cv(0), 32'd1);
    chk("wr_rd_word", 0, dv(0), 32'h77);
    pop(0);

    ov0 = obs_ov[0];
    for (int k = 1; k <= 5; k++) send_frame(0, 9'(k), 0, 0, (k == 5) ? 30 : 0);
    chk("ovr_count", 0, cv(0), 32'd4);
    chk("ovr_pulses", 0, obs_ov[0] - ov0, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovr_pop_word", 0, dv(0), k);
      pop(0);
    end

    send_frame(0, 9'h033, 0, 0, 20);
    rxd[0] = 1'b0;
    idle(OS * 4);
    do_reset();
    idle(40);
    send_frame(0, 9'h05A, 0, 0, 30);
    chk("post_rst_count", 0, cv(0), 32'd1);
    chk("post_rst_word", 0, dv(0), 32'h5A);
    pop(0);

    random_phase(0, 24);
    random_phase(1, 24);
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_receiver_fifo.md
Name: uart_receiver_fifo

Overview:
Parametrised successor to the single-format UART receiver feeding the CPU input port.
- Format is configurable: data bits, parity mode, stop bits, oversampling ratio.
- Majority-vote sampling, a synchronised rxd input, and an internal FIFO sized by parameter.
- Reports per-frame framing, parity and overrun events.
- Keeps the existing dout/empty/re read interface, so it drops into the top-level in place of the current receiver.

Parameters:
- CLOCK_FREQUENCY, 100_000_000, system clock in Hz.
- BAUD_RATE, 115_200, line rate in bit/s.
- OVERSAMPLE, 16, sample ticks per bit. Even, 8..32.
- DATA_BITS, 8, payload width, 5..9, sent LSB first.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 16, entries. Power of two, >= 2.

Ports:
- clk_in  in  1  system clock. All logic is on the rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rxd  in  1  serial line. Idle high. Asynchronous to clk_in.
- dout  out  DATA_BITS  FIFO head word. Valid whenever empty=0 (first-word fall-through).
- empty  out  1  FIFO holds no words.
- re  in  1  pop request. Pops the head on a clock edge where re=1 and empty=0. Ignored when empty=1.
- count  out  $clog2(FIFO_DEPTH)+1  number of words held.
- frame_err  out  1  one-cycle pulse: a stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- overrun  out  1  one-cycle pulse: a good frame arrived while the FIFO was full.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - FSM goes to IDLE; tick counter, FIFO pointers and count clear.
  - Outputs: empty=1, count=0, dout=0, all error pulses 0.
  - Synchroniser flops reset to 1.
  - Reset asserted mid-frame discards the partial frame. No error pulse is produced.
- rxd passes through 2 flops (rxs) before any use.
- Tick generator:
  - DIV = CLOCK_FREQUENCY / (BAUD_RATE*OVERSAMPLE), integer division, minimum 1.
  - It pulses tick for one clock every DIV clocks.
  - It free-runs but is re-phased to 0 on the IDLE->START transition.
- Per bit, sc counts ticks 0..OVERSAMPLE-1. At sc = OVERSAMPLE/2+1 the bit value is the 2-of-3 majority of rxs at ticks OVERSAMPLE/2-1, /2, /2+1.
- FSM:
  - IDLE: a falling edge of rxs moves to START with sc=0.
  - START: at the vote point, a majority 1 is a false start and returns to IDLE with no pulse. A 0 waits for the bit end, then goes to DATA with bit index 0.
  - DATA: shifts DATA_BITS votes in LSB first. Goes to PARITY if PARITY!=0, else to STOP.
  - PARITY: expected value is the XOR of the data bits (even), inverted for odd. A mismatch latches pe.
  - STOP: STOP_BITS bit times. Any stop vote of 0 latches fe.
  - Frame resolution happens at the vote point of the last stop bit. The FSM then returns to IDLE immediately, without waiting for the bit end, so back-to-back frames are accepted.
- Frame resolution, priority order:
  - fe set: frame_err pulses, word dropped. parity_err is not asserted even if pe is also set.
  - else pe set: parity_err pulses, word dropped.
  - else FIFO full: overrun pulses, word dropped, FIFO contents unchanged.
  - else the word is written at the tail.
- FIFO:
  - Write and pop in the same cycle are both performed. count is unchanged.
  - A write into an empty FIFO shows on dout with empty=0 in the next cycle (1-cycle latency from frame resolution).
  - Pointers wrap modulo FIFO_DEPTH. The full/empty distinction uses count.
  - re with empty=1 has no effect: no underflow, count stays 0.

Test Plan:
Use CLOCK_FREQUENCY=1_600_000, BAUD_RATE=100_000, OVERSAMPLE=16 (DIV=1, one bit = 16 clocks) unless noted.
- Reset then idle line: empty=1, count=0, dout=0, no pulses for 1000 clocks. A 5-clock low glitch on rxd produces no word.
- 8N1, send 0xA5 then 0x3C back-to-back with 1 stop bit: count reaches 2, dout=0xA5. Pop with re -> dout=0x3C. Pop again -> empty=1.
- PARITY=1, DATA_BITS=7, STOP_BITS=2:
  - Send 0x41 with correct parity bit 0 -> word 0x41.
  - Send 0x41 with parity bit 1 -> parity_err single pulse, count unchanged.
- Stop bit driven low on 0x55: frame_err single pulse, no word. The next frame 0x12 is received correctly.
- FIFO_DEPTH=4, send 5 frames 0x01..0x05 without popping: count=4, overrun pulses once on frame 5. Pops yield 0x01..0x04.
- Assert re on the exact cycle frame 0x77 is written into a FIFO holding 1 word: count stays 1, dout=0x77 next. Assert rst_in low mid-DATA: empty=1 immediately, no pulse, the next full frame is received.
